multicycle_alu: RTL and testbench
=================================

// Module: multicycle_alu
// PURPOSE
//   Execute-stage ALU, directly downstream of the ALU control decoder. Consumes the 4-bit
//   ALUOperation code plus two operands and produces a registered result.
//   Logic ops and ADD complete in 1 cycle. MULT and SQU run a radix-2 shift-add multiplier
//   over WIDTH cycles.
//   A Start/Busy/Done handshake lets the control path stall the datapath while a multiply runs.
// PARAMETERS
//   WIDTH  32  operand and result width in bits
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      asynchronous, active-low reset
//   Start         in   1      request; sampled only in IDLE
//   ALUOperation  in   4      0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 MOV, 0101 SQU,
//                             0110 MULT; all other codes are invalid
//   A             in   WIDTH  operand A (rs)
//   B             in   WIDTH  operand B (rt/immediate)
//   ALUResult     out  WIDTH  registered result; holds its value until the next completion
//   Zero          out  1      combinational (ALUResult == 0)
//   Busy          out  1      high while the multiplier iterates
//   Done          out  1      one-cycle pulse when ALUResult is updated
//   Error         out  1      one-cycle pulse together with Done for an invalid op code
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, ALUResult=0, Busy=0, Done=0, Error=0; therefore Zero=1.
//     Any in-flight multiply is discarded.
//   States: IDLE, MUL.
//   IDLE, Start=0 at edge: Done<=0, Error<=0; ALUResult is held.
//   IDLE, Start=1 at edge k, single-cycle op:
//     ALUResult<=f(A,B), Done<=1, Error<=0; state stays IDLE. Latency is 1 cycle.
//     AND A&B; OR A|B; NOR ~(A|B); ADD (A+B) mod 2^WIDTH with no overflow flag; MOV = A.
//   IDLE, Start=1 at edge k, invalid code: ALUResult<=0, Done<=1, Error<=1.
//   IDLE, Start=1 at edge k, MULT/SQU: latch mcand=A and mplier=(SQU ? A : B).
//     acc<=0, cnt<=WIDTH, Busy<=1, Done<=0, state->MUL.
//   MUL, each edge: if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1; cnt--.
//   Completion: the iteration that takes cnt to 0 occurs at edge k+WIDTH. At that edge
//     ALUResult<=final acc (low WIDTH bits of the product), Done<=1, Busy<=0, state->IDLE.
//     Fixed latency of WIDTH cycles; no early termination.
//   Start while Busy=1 is ignored. It is not queued.
//   A, B and ALUOperation may change freely after the Start edge; latched operands are used.
//   Back-to-back: Start may be asserted in the same cycle Done is high.
//     The new op is accepted at that edge.
//   ALUResult is unchanged while Busy=1. It updates only on Done.
// TESTING
//   1. Reset, then ADD with A=FFFFFFFF, B=00000001, Start at edge k.
//      -> at k+1 Done=1, ALUResult=0, Zero=1, Error=0.
//   2. MULT with A=00012345, B=00000100.
//      -> Busy=1 for 32 cycles; Done at edge k+32; ALUResult=01234500; Zero=0.
//   3. SQU with A=FFFFFFFF and B=don't-care.
//      -> Done at k+32; ALUResult=00000001.
//   4. Start a MULT (3x5), then at k+5 pulse Start with ADD and change A/B.
//      -> second Start is ignored; ALUResult=0000000F at k+32; exactly one Done pulse.
//   5. Start a MULT, then drive reset low at k+10.
//      -> Busy=0, Done=0, ALUResult=0, Zero=1 immediately.
//      -> after release, an AND of F0F0F0F0 and FF00FF00 gives F000F000 at the next edge.
//   6. ALUOperation=1001 with Start -> next cycle Done=1, Error=1, ALUResult=0.
//      -> then a NOR of 0 and 0 issued back-to-back gives FFFFFFFF, Error=0.

Source files
------------

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: logic ops, ADD and MOV finish in one cycle. MULT and SQU run a
// radix-2 shift-add multiplier for a fixed WIDTH cycles behind a Start/Busy/Done handshake.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_MOV  = 4'b0100;
    localparam logic [3:0] OP_SQU  = 4'b0101;
    localparam logic [3:0] OP_MULT = 4'b0110;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] acc_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // One partial-product step; the final step's sum is forwarded straight into the result.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    done_d = 1'b1;
                    case (ALUOperation)
                        OP_AND:  result_d = A & B;
                        OP_OR:   result_d = A | B;
                        OP_NOR:  result_d = ~(A | B);
                        OP_ADD:  result_d = A + B;
                        OP_MOV:  result_d = A;
                        OP_SQU, OP_MULT: begin
                            mcand_d  = A;
                            mplier_d = (ALUOperation == OP_SQU) ? A : B;
                            acc_d    = '0;
                            cnt_d    = CNT_INIT;
                            done_d   = 1'b0;
                            state_d  = MUL;
                        end
                        default: begin
                            result_d = '0;
                            error_d  = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = acc_sum;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ALUResult = result_q;
    assign Zero      = (result_q == '0);
    assign Busy      = (state_q == MUL);
    assign Done      = done_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expected results are queued at issue time and
// compared whenever the DUT pulses Done.
module tb_multicycle_alu;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             Start = 1'b0;
    logic [3:0]       ALUOperation = 4'b0000;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Busy;
    logic             Done;
    logic             Error;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             error;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   vector_count = 0;
    int   miscompare_count = 0;
    int   done_count = 0;
    int   done_before = 0;

    multicycle_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .Start(Start),
        .ALUOperation(ALUOperation),
        .A(A),
        .B(B),
        .ALUResult(ALUResult),
        .Zero(Zero),
        .Busy(Busy),
        .Done(Done),
        .Error(Error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        e.error = 1'b0;
        case (op)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0010: e.result = ~(a | b);
            4'b0011: e.result = a + b;
            4'b0100: e.result = a;
            4'b0101: e.result = a * a;
            4'b0110: e.result = a * b;
            default: begin
                e.result = '0;
                e.error  = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Drives a request that is sampled at the next rising edge; returns 1ns after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUOperation = op;
        A = a;
        B = b;
        Start = 1'b1;
        sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        Start = 1'b0;
        ALUOperation = 4'($urandom_range(0, 15));
        A = $urandom;
        B = $urandom;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n = 0;
        while (!Done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!Done) checkOutput(tag, 32'd0, 32'd1);
    endtask

    // Called 1ns after the accepting edge of a multiply; checks the full Busy window.
    task automatic checkMulWindow(input logic [31:0] held, input string tag);
        checkOutput({tag, "_busy_start"}, {31'b0, Busy}, 32'd1);
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_busy"}, {31'b0, Busy}, 32'd1);
            checkOutput({tag, "_no_done"}, {31'b0, Done}, 32'd0);
            checkOutput({tag, "_held"}, ALUResult, held);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_k32"}, {31'b0, Done}, 32'd1);
        checkOutput({tag, "_busy_end"}, {31'b0, Busy}, 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset && Done) begin
                done_count++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    checkOutput("result", ALUResult, mon_exp.result);
                    checkOutput("error", {31'b0, Error}, {31'b0, mon_exp.error});
                    checkOutput("zero", {31'b0, Zero}, {31'b0, (mon_exp.result == '0)});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #1;
        checkOutput("rst_result", ALUResult, 32'h0);
        checkOutput("rst_zero", {31'b0, Zero}, 32'd1);
        checkOutput("rst_busy", {31'b0, Busy}, 32'd0);
        checkOutput("rst_done", {31'b0, Done}, 32'd0);
        checkOutput("rst_error", {31'b0, Error}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Wrap-around ADD
        applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("add_done_k1", {31'b0, Done}, 32'd1);
        checkOutput("add_zero", {31'b0, Zero}, 32'd1);

        // MULT and SQU with full Busy-window checks
        applyStimulus(4'b0110, 32'h0001_2345, 32'h0000_0100);
        checkMulWindow(32'h0, "mult");
        checkOutput("mult_zero", {31'b0, Zero}, 32'd0);
        applyStimulus(4'b0101, 32'hFFFF_FFFF, $urandom);
        checkMulWindow(32'h0123_4500, "squ");

        // Start while Busy is ignored
        done_before = done_count;
        applyStimulus(4'b0110, 32'd3, 32'd5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ALUOperation = 4'b0011;
        A = 32'h1111_1111;
        B = 32'h2222_2222;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        waitDone(WIDTH + 4, "ignored_start_timeout");
        repeat (4) @(posedge clk);
        #1;
        checkOutput("one_done_pulse", 32'(done_count - done_before), 32'd1);
        checkOutput("ignored_result", ALUResult, 32'h0000_000F);

        // Reset in the middle of a multiply
        applyStimulus(4'b0110, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        sb_q.delete();
        #1;
        checkOutput("midrst_busy", {31'b0, Busy}, 32'd0);
        checkOutput("midrst_done", {31'b0, Done}, 32'd0);
        checkOutput("midrst_result", ALUResult, 32'h0);
        checkOutput("midrst_zero", {31'b0, Zero}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checkOutput("and_after_rst", ALUResult, 32'hF000_F000);

        // Invalid code, then NOR issued back-to-back
        applyStimulus(4'b1001, 32'h1234_5678, 32'h9ABC_DEF0);
        checkOutput("inv_done", {31'b0, Done}, 32'd1);
        checkOutput("inv_error", {31'b0, Error}, 32'd1);
        applyStimulus(4'b0010, 32'h0, 32'h0);
        checkOutput("nor_done", {31'b0, Done}, 32'd1);
        checkOutput("nor_error", {31'b0, Error}, 32'd0);

        // Random mix of all codes
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom);
            waitDone(WIDTH + 4, "rand_timeout");
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
